// File: rtl/qos_pkg.sv
// qos_pkg: shared definitions for the multichannel QoS engine.
//   modo_t    arbitration mode encodings (cfg_modo)
//   estado_t  engine FSM states
//   wrap_add  modular index helper for cyclic searches (non-power-of-2 safe)
package qos_pkg;

  localparam int unsigned MODO_W = 2;

  typedef enum logic [MODO_W-1:0] {
    MODO_RR   = 2'd0,
    MODO_WRR  = 2'd1,
    MODO_TBL  = 2'd2,
    MODO_PRIO = 2'd3
  } modo_t;

  typedef enum logic {
    CONFIG = 1'b0,
    ACTIVE = 1'b1
  } estado_t;

  // base < n and off < n, so a single conditional subtract is enough
  function automatic int unsigned wrap_add(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/qos_fifo_vc.sv
// qos_fifo_vc: single virtual-channel FIFO.
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request (caller guarantees !full)
//   pop           read request (caller guarantees !empty)
//   head          word at the read pointer (combinational)
//   count         occupancy 0..FIFO_DEPTH
//   full, empty   occupancy flags
module qos_fifo_vc
  import qos_pkg::*;
#(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/qos_multicanal.sv
// qos_multicanal: N virtual-channel QoS engine with per-VC pause/continue
// hysteresis, selectable arbitration and a backpressured registered egress.
//   clk, rst, enb          clock, sync active-high reset, global enable (0 freezes)
//   iniciar                CONFIG->ACTIVE, latches all cfg_* inputs
//   push_vld/vc_id/data_word  ingress word
//   out_rdy                egress ready
//   cfg_umbral_max/min     pause / continue thresholds
//   cfg_modo               0 RR, 1 WRR, 2 table, 3 strict priority
//   cfg_pesos              per-VC weights (WRR)
//   cfg_tbl_vc/cfg_tbl_peso  arbitration table (queue, weight) entries
//   error_full             pulse: push to a full queue was dropped
//   pausa / continuar      level pause flag / pulse on release
//   idle                   ACTIVE, all queues empty and no word held
//   data_out / out_vld     egress word
// Optional feature: define QOS_STRICT_PRIO_EN to give cfg_modo=3 strict
// lowest-index priority; otherwise mode 3 arbitrates as round-robin.
module qos_multicanal
  import qos_pkg::*;
#(
  parameter  int unsigned NUM_VC     = 4,
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned MAX_WEIGHT = 64,
  parameter  int unsigned TABLE_SIZE = 8,
  localparam int unsigned VC_W       = $clog2(NUM_VC),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned WGT_W      = $clog2(MAX_WEIGHT),
  localparam int unsigned TBL_W      = $clog2(TABLE_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  input  logic                        iniciar,
  input  logic                        push_vld,
  input  logic [VC_W-1:0]             vc_id,
  input  logic [DATA_W-1:0]           data_word,
  input  logic                        out_rdy,
  input  logic [CNT_W-1:0]            cfg_umbral_max,
  input  logic [CNT_W-1:0]            cfg_umbral_min,
  input  logic [MODO_W-1:0]           cfg_modo,
  input  logic [NUM_VC*WGT_W-1:0]     cfg_pesos,
  input  logic [TABLE_SIZE*VC_W-1:0]  cfg_tbl_vc,
  input  logic [TABLE_SIZE*WGT_W-1:0] cfg_tbl_peso,
  output logic [NUM_VC-1:0]           error_full,
  output logic [NUM_VC-1:0]           pausa,
  output logic [NUM_VC-1:0]           continuar,
  output logic                        idle,
  output logic [DATA_W-1:0]           data_out,
  output logic                        out_vld
);

  estado_t                     estado;
  modo_t                       modo;
  logic [CNT_W-1:0]            umbral_max, umbral_min;
  logic [NUM_VC*WGT_W-1:0]     pesos;
  logic [TABLE_SIZE*VC_W-1:0]  tbl_vc;
  logic [TABLE_SIZE*WGT_W-1:0] tbl_peso;

  // Arbitration state: rr_ptr/tbl_ptr point one past the last selection
  logic [VC_W-1:0]  rr_ptr, cur_vc;
  logic [WGT_W-1:0] credit;
  logic [TBL_W-1:0] tbl_ptr;

  logic [NUM_VC-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head  [NUM_VC];
  logic [CNT_W-1:0]  fifo_count [NUM_VC];
  logic [CNT_W-1:0]  count_next [NUM_VC];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    qos_fifo_vc #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[v]),
      .pop   (fifo_pop[v]),
      .din   (data_word),
      .head  (fifo_head[v]),
      .count (fifo_count[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v])
    );
  end

  logic activo, pop_slot, push_ok, push_drop;
  assign activo    = enb && (estado == ACTIVE);
  assign pop_slot  = activo && (!out_vld || out_rdy);
  assign push_ok   = activo && push_vld && !fifo_full[vc_id];
  assign push_drop = activo && push_vld &&  fifo_full[vc_id];

  logic             rr_hit, tbl_hit, gnt_vld;
  logic [VC_W-1:0]  rr_vc, tbl_sel_vc, gnt_vc, ent_vc, nxt_rr_ptr, nxt_cur_vc;
  logic [TBL_W-1:0] tbl_ent, nxt_tbl_ptr;
  logic [WGT_W-1:0] w_sel, nxt_credit;
  int unsigned      idx;

  always_comb begin
    idx        = 0;
    ent_vc     = '0;
    rr_hit     = 1'b0;
    rr_vc      = '0;
    tbl_hit    = 1'b0;
    tbl_ent    = '0;
    tbl_sel_vc = '0;
    w_sel      = '0;
    gnt_vld    = 1'b0;
    gnt_vc     = '0;
    nxt_rr_ptr = rr_ptr;
    nxt_cur_vc = cur_vc;
    nxt_credit = credit;
    nxt_tbl_ptr = tbl_ptr;

    // First non-empty queue cyclically from rr_ptr (RR and WRR reselection)
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      idx = wrap_add(32'(rr_ptr), i, NUM_VC);
      if (!rr_hit && !fifo_empty[VC_W'(idx)]) begin
        rr_hit = 1'b1;
        rr_vc  = VC_W'(idx);
      end
    end

    // First table entry from tbl_ptr whose queue has data; empty entries skipped
    for (int unsigned k = 0; k < TABLE_SIZE; k++) begin
      idx    = wrap_add(32'(tbl_ptr), k, TABLE_SIZE);
      ent_vc = tbl_vc[idx*VC_W +: VC_W];
      if (!tbl_hit && (32'(ent_vc) < NUM_VC) && !fifo_empty[ent_vc]) begin
        tbl_hit    = 1'b1;
        tbl_ent    = TBL_W'(idx);
        tbl_sel_vc = ent_vc;
      end
    end

    case (modo)
      MODO_WRR: begin
        if ((credit != '0) && !fifo_empty[cur_vc]) begin
          gnt_vld    = 1'b1;
          gnt_vc     = cur_vc;
          nxt_credit = credit - 1'b1;
        end else if (rr_hit) begin
          gnt_vld    = 1'b1;
          gnt_vc     = rr_vc;
          nxt_cur_vc = rr_vc;
          nxt_rr_ptr = VC_W'(wrap_add(32'(rr_vc), 1, NUM_VC));
          w_sel      = pesos[32'(rr_vc)*WGT_W +: WGT_W];
          nxt_credit = (w_sel == '0) ? '0 : w_sel - 1'b1;
        end
      end
      MODO_TBL: begin
        if ((credit != '0) && !fifo_empty[cur_vc]) begin
          gnt_vld    = 1'b1;
          gnt_vc     = cur_vc;
          nxt_credit = credit - 1'b1;
        end else if (tbl_hit) begin
          gnt_vld     = 1'b1;
          gnt_vc      = tbl_sel_vc;
          nxt_cur_vc  = tbl_sel_vc;
          nxt_tbl_ptr = TBL_W'(wrap_add(32'(tbl_ent), 1, TABLE_SIZE));
          w_sel       = tbl_peso[32'(tbl_ent)*WGT_W +: WGT_W];
          nxt_credit  = (w_sel == '0) ? '0 : w_sel - 1'b1;
        end
      end
`ifdef QOS_STRICT_PRIO_EN
      MODO_PRIO: begin
        // descending scan so the lowest non-empty index is the final winner
        for (int unsigned i = NUM_VC; i > 0; i--) begin
          if (!fifo_empty[VC_W'(i-1)]) begin
            gnt_vld = 1'b1;
            gnt_vc  = VC_W'(i-1);
          end
        end
      end
`endif
      default: begin
        if (rr_hit) begin
          gnt_vld    = 1'b1;
          gnt_vc     = rr_vc;
          nxt_rr_ptr = VC_W'(wrap_add(32'(rr_vc), 1, NUM_VC));
        end
      end
    endcase
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      fifo_push[v]  = push_ok && (vc_id == VC_W'(v));
      fifo_pop[v]   = pop_slot && gnt_vld && (gnt_vc == VC_W'(v));
      count_next[v] = fifo_count[v] + CNT_W'(fifo_push[v]) - CNT_W'(fifo_pop[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= CONFIG;
      modo       <= MODO_RR;
      umbral_max <= '0;
      umbral_min <= '0;
      pesos      <= '0;
      tbl_vc     <= '0;
      tbl_peso   <= '0;
      rr_ptr     <= '0;
      cur_vc     <= '0;
      credit     <= '0;
      tbl_ptr    <= '0;
      data_out   <= '0;
      out_vld    <= 1'b0;
      error_full <= '0;
      pausa      <= '0;
      continuar  <= '0;
    end else begin
      // Pulses last one cycle; levels and queue state hold while enb=0.
      // A pending release is re-evaluated from the frozen state once enb returns.
      error_full <= '0;
      continuar  <= '0;
      if (enb) begin
        case (estado)
          CONFIG: begin
            if (iniciar) begin
              estado     <= ACTIVE;
              modo       <= modo_t'(cfg_modo);
              umbral_max <= cfg_umbral_max;
              umbral_min <= cfg_umbral_min;
              pesos      <= cfg_pesos;
              tbl_vc     <= cfg_tbl_vc;
              tbl_peso   <= cfg_tbl_peso;
            end
          end
          ACTIVE: begin
            if (pop_slot) begin
              out_vld <= gnt_vld;
              if (gnt_vld) begin
                data_out <= fifo_head[gnt_vc];
                rr_ptr   <= nxt_rr_ptr;
                cur_vc   <= nxt_cur_vc;
                credit   <= nxt_credit;
                tbl_ptr  <= nxt_tbl_ptr;
              end
            end
            for (int unsigned v = 0; v < NUM_VC; v++) begin
              if (push_drop && (vc_id == VC_W'(v))) error_full[v] <= 1'b1;
              if (pausa[v] && (count_next[v] <= umbral_min)) begin
                pausa[v]     <= 1'b0;
                continuar[v] <= 1'b1;
              end else if (count_next[v] >= umbral_max) begin
                pausa[v] <= 1'b1;
              end
            end
          end
          default: estado <= CONFIG;
        endcase
      end
    end
  end

  assign idle = (estado == ACTIVE) && (&fifo_empty) && !out_vld;

endmodule

// File: tb/tb_qos_multicanal.sv
// tb_qos_multicanal: randomized + directed stimulus for qos_multicanal, checked
// every cycle against a queue-based behavioural model of the QoS engine.
module tb_qos_multicanal;

  localparam int unsigned NV = 4, DW = 8, DEPTH = 16, WG = 6, TS = 8, VCW = 2, CW = 5;

  logic              clk = 1'b0;
  logic              rst, enb, iniciar, push_vld, out_rdy;
  logic [VCW-1:0]    vc_id;
  logic [DW-1:0]     data_word;
  logic [CW-1:0]     cfg_umbral_max, cfg_umbral_min;
  logic [1:0]        cfg_modo;
  logic [NV*WG-1:0]  cfg_pesos;
  logic [TS*VCW-1:0] cfg_tbl_vc;
  logic [TS*WG-1:0]  cfg_tbl_peso;
  logic [NV-1:0]     error_full, pausa, continuar;
  logic              idle, out_vld;
  logic [DW-1:0]     data_out;

  always #5 clk = ~clk;

  qos_multicanal #(
    .NUM_VC(NV), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_WEIGHT(64), .TABLE_SIZE(TS)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .push_vld(push_vld),
    .vc_id(vc_id), .data_word(data_word), .out_rdy(out_rdy),
    .cfg_umbral_max(cfg_umbral_max), .cfg_umbral_min(cfg_umbral_min), .cfg_modo(cfg_modo),
    .cfg_pesos(cfg_pesos), .cfg_tbl_vc(cfg_tbl_vc), .cfg_tbl_peso(cfg_tbl_peso),
    .error_full(error_full), .pausa(pausa), .continuar(continuar), .idle(idle),
    .data_out(data_out), .out_vld(out_vld)
  );

  int unsigned total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] q [NV][$];
  bit            m_active, m_vld;
  logic [DW-1:0] m_dout;
  bit [NV-1:0]   m_err, m_cont, m_pausa;
  int            m_mode, m_max, m_min;
  int            m_w [NV];
  int            m_tvc [TS];
  int            m_tw [TS];
  int            last_vc, last_ent, cred;   // last granted queue / table entry, remaining burst

  function automatic int next_nonempty(int after);
    for (int k = 1; k <= NV; k++) begin
      int v;
      v = (after + k) % NV;
      if (q[v].size() > 0) return v;
    end
    return -1;
  endfunction

  function automatic int pick();
    int v, mode;
    mode = m_mode;
`ifndef QOS_STRICT_PRIO_EN
    if (mode == 3) mode = 0;
`endif
    if (mode == 3) begin
      for (int i = 0; i < NV; i++) if (q[i].size() > 0) return i;
      return -1;
    end else if (mode == 1) begin
      if (cred > 0 && last_vc >= 0 && q[last_vc].size() > 0) begin
        cred--;
        return last_vc;
      end
      v = next_nonempty(last_vc);
      if (v < 0) return -1;
      last_vc = v;
      cred = ((m_w[v] == 0) ? 1 : m_w[v]) - 1;
      return v;
    end else if (mode == 2) begin
      if (cred > 0 && last_ent >= 0 && q[m_tvc[last_ent]].size() > 0) begin
        cred--;
        return m_tvc[last_ent];
      end
      for (int k = 1; k <= TS; k++) begin
        int e;
        e = (last_ent + k) % TS;
        if (q[m_tvc[e]].size() > 0) begin
          last_ent = e;
          cred = ((m_tw[e] == 0) ? 1 : m_tw[e]) - 1;
          return m_tvc[e];
        end
      end
      return -1;
    end
    v = next_nonempty(last_vc);
    if (v >= 0) last_vc = v;
    return v;
  endfunction

  task automatic model_step();
    int g, n;
    bit [NV-1:0] full_pre;
    if (rst) begin
      for (int v = 0; v < NV; v++) q[v].delete();
      m_active = 0; m_vld = 0; m_dout = '0; m_err = '0; m_cont = '0; m_pausa = '0;
      last_vc = -1; last_ent = -1; cred = 0;
    end else begin
      m_err = '0;
      m_cont = '0;
      if (enb) begin
        if (!m_active) begin
          if (iniciar) begin
            m_active = 1;
            m_mode = int'(cfg_modo);
            m_max = int'(cfg_umbral_max);
            m_min = int'(cfg_umbral_min);
            for (int v = 0; v < NV; v++) m_w[v] = int'(cfg_pesos[v*WG +: WG]);
            for (int k = 0; k < TS; k++) begin
              m_tvc[k] = int'(cfg_tbl_vc[k*VCW +: VCW]);
              m_tw[k]  = int'(cfg_tbl_peso[k*WG +: WG]);
            end
          end
        end else begin
          for (int v = 0; v < NV; v++) full_pre[v] = (q[v].size() == DEPTH);
          if (!m_vld || out_rdy) begin
            g = pick();
            if (g >= 0) begin
              m_dout = q[g].pop_front();
              m_vld = 1;
            end else m_vld = 0;
          end
          if (push_vld) begin
            if (full_pre[vc_id]) m_err[vc_id] = 1'b1;
            else q[vc_id].push_back(data_word);
          end
          for (int v = 0; v < NV; v++) begin
            n = q[v].size();
            if (m_pausa[v] && n <= m_min) begin
              m_pausa[v] = 1'b0;
              m_cont[v] = 1'b1;
            end else if (n >= m_max) m_pausa[v] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    bit m_idle;
    m_idle = m_active && !m_vld;
    for (int v = 0; v < NV; v++) if (q[v].size() > 0) m_idle = 0;
    chk("out_vld",    32'(out_vld),    32'(m_vld));
    chk("data_out",   32'(data_out),   32'(m_dout));
    chk("error_full", 32'(error_full), 32'(m_err));
    chk("pausa",      32'(pausa),      32'(m_pausa));
    chk("continuar",  32'(continuar),  32'(m_cont));
    chk("idle",       32'(idle),       32'(m_idle));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    push_vld = 0; iniciar = 0; enb = 1; out_rdy = 1;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic start(input int modo, input int mx, input int mn);
    cfg_modo = 2'(modo);
    cfg_umbral_max = CW'(mx);
    cfg_umbral_min = CW'(mn);
    iniciar = 1;
    tick();
    iniciar = 0;
  endtask

  task automatic push(input int vc, input int d);
    push_vld = 1;
    vc_id = VCW'(vc);
    data_word = DW'(d);
    tick();
    push_vld = 0;
  endtask

  task automatic rand_cfg();
    int unsigned mx;
    mx = $urandom_range(1, DEPTH);
    cfg_umbral_max = CW'(mx);
    cfg_umbral_min = CW'($urandom_range(0, mx - 1));
    cfg_modo = 2'($urandom_range(0, 3));
    for (int v = 0; v < NV; v++) cfg_pesos[v*WG +: WG] = WG'($urandom_range(0, 5));
    for (int k = 0; k < TS; k++) begin
      cfg_tbl_vc[k*VCW +: VCW]  = VCW'($urandom_range(0, NV - 1));
      cfg_tbl_peso[k*WG +: WG]  = WG'($urandom_range(0, 4));
    end
  endtask

  // Random traffic; cfg_* and iniciar are also scrambled to show they are ignored while ACTIVE
  task automatic traffic(input int n, input int p_push, input int p_rdy, input int p_off);
    for (int i = 0; i < n; i++) begin
      push_vld  = ($urandom_range(0, 99) < p_push);
      vc_id     = VCW'($urandom_range(0, NV - 1));
      data_word = DW'($urandom);
      out_rdy   = ($urandom_range(0, 99) < p_rdy);
      enb       = ($urandom_range(0, 99) >= p_off);
      iniciar   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) rand_cfg();
      tick();
    end
    push_vld = 0; iniciar = 0; enb = 1;
  endtask

  task automatic drain(input int n);
    out_rdy = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; enb = 1; iniciar = 0; push_vld = 0; vc_id = '0; data_word = '0; out_rdy = 1;
    cfg_umbral_max = CW'(12); cfg_umbral_min = CW'(4); cfg_modo = 2'd0;
    cfg_pesos = '0; cfg_tbl_vc = '0; cfg_tbl_peso = '0;
    tick();
    rst = 0;

    // pushes in CONFIG are dropped silently, then iniciar
    for (int i = 0; i < 3; i++) push(i, 8'hA0 + i);
    start(0, 12, 4);
    chk("idle_after_iniciar", 32'(idle), 32'd1);

    // round-robin, 2 words per queue
    for (int r = 0; r < 2; r++) for (int v = 0; v < NV; v++) push(v, (v << 4) | r);
    drain(12);
    traffic(250, 60, 70, 10);

    // WRR with weights {1,2,3,4}
    do_reset();
    cfg_pesos = {6'd4, 6'd3, 6'd2, 6'd1};
    start(1, 16, 0);
    out_rdy = 0;
    for (int r = 0; r < 10; r++) for (int v = 0; v < NV; v++) push(v, (v << 4) | r);
    drain(45);
    traffic(250, 60, 70, 10);

    // table {(2,3),(0,1),(3,0)}, rest (1,1); VC1 left empty
    do_reset();
    cfg_tbl_vc   = {2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2};
    cfg_tbl_peso = {6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd0, 6'd1, 6'd3};
    start(2, 16, 0);
    out_rdy = 0;
    for (int r = 0; r < 6; r++) begin
      push(0, 8'h00 | r);
      push(2, 8'h20 | r);
      push(3, 8'h30 | r);
    end
    drain(25);
    traffic(250, 60, 70, 10);

    // thresholds 12/4 on VC1 with egress stalled, then release
    do_reset();
    start(0, 12, 4);
    out_rdy = 0;
    for (int i = 0; i < 19; i++) push(1, i);
    chk("pausa1_full", 32'(pausa[1]), 32'd1);
    drain(25);

    // egress stall: data_out must hold
    for (int i = 0; i < 4; i++) push(i, 8'h50 + i);
    out_rdy = 0;
    for (int i = 0; i < 5; i++) tick();
    drain(8);

    // mode 3 (strict priority only when the feature is built in)
    do_reset();
    start(3, 10, 3);
    traffic(250, 70, 50, 10);

    // random configurations, with a reset mid-stream
    for (int p = 0; p < 3; p++) begin
      do_reset();
      rand_cfg();
      start(int'(cfg_modo), int'(cfg_umbral_max), int'(cfg_umbral_min));
      traffic(200, 65, 60, 15);
    end
    rst = 1;
    tick();
    rst = 0;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_pausa", 32'(pausa), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    push(0, 8'h77);
    chk("config_drop_idle", 32'(idle), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
